serial_word_packer: RTL and testbench

- Serial-to-parallel stage that sits directly downstream of the 1-bit registered delay-line output (`z`) of the redundant-FF test design.
- Collects frame-aligned serial bits into WIDTH-bit words and presents each word on a valid/ready output holding register.
- Provides sticky overflow and framing-error flags, so that synthesis of the full chain can be inspected stage by stage.

---
 rtl/serial_word_packer.sv | 120 ++++++++++++
 tb/tb_serial_word_packer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_packer.sv
// Serial-to-parallel word packer for the delay-line output.
// Frame-aligned bits in, valid/ready words out, sticky error flags.
module serial_word_packer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             sof,
  input  logic             out_ready,
  input  logic             clear_flags,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             overflow,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [CW-1:0]    w_cnt_eff;
  logic [CW-1:0]    w_pos;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] w_sh_nxt;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic             r_ferr;
  logic             w_ferr_nxt;
  logic             w_accept;
  logic             w_done;
  logic             w_load;
  logic             w_drop;
  logic             w_ferr_set;

  // State register: reset drops back to hunting for a frame start
  always_ff @(posedge clk) begin
    if (reset_) r_state <= HUNT;
    else        r_state <= w_state_nxt;
  end

  // Next state: any qualified sof locks onto framing; SHIFT never leaves
  always_comb begin
    w_state_nxt = r_state;
    if (bit_valid && sof) w_state_nxt = SHIFT;
  end

  // Outputs of the FSM: bit placement, completion, handshake and flags
  always_comb begin
    w_accept   = bit_valid && (sof || r_state == SHIFT);
    w_cnt_eff  = sof ? '0 : r_cnt;
    w_pos      = (MSB_FIRST != 0) ? CW'(WIDTH-1) - w_cnt_eff
                                  : w_cnt_eff;
    w_word     = sof ? '0 : r_sh;
    w_word[w_pos] = bit_in;
    w_done     = w_accept && !sof && (r_cnt == CW'(WIDTH-1));
    w_ferr_set = bit_valid && sof && (r_state == SHIFT) && (r_cnt != '0);
    w_load     = w_done && (!r_valid || out_ready);
    w_drop     = w_done && r_valid && !out_ready;

    w_cnt_nxt = r_cnt;
    w_sh_nxt  = r_sh;
    if (w_accept) begin
      w_cnt_nxt = w_done ? '0 : w_cnt_eff + CW'(1);
      w_sh_nxt  = w_done ? '0 : w_word;
    end

    w_valid_nxt = r_valid;
    w_data_nxt  = r_data;
    if (w_load) begin
      w_valid_nxt = 1'b1;
      w_data_nxt  = w_word;
    end else if (r_valid && out_ready) begin
      w_valid_nxt = 1'b0;
    end

    // a new event in the same cycle as a clear keeps the flag set
    w_ovf_nxt  = w_drop || (r_ovf && !clear_flags);
    w_ferr_nxt = w_ferr_set || (r_ferr && !clear_flags);
  end

  // Datapath registers: bit counter, accumulator, output holding reg
  always_ff @(posedge clk) begin
    if (reset_) begin
      r_cnt   <= '0;
      r_sh    <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_sh    <= w_sh_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ovf   <= w_ovf_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign overflow  = r_ovf;
  assign frame_err = r_ferr;

endmodule

// File: tb/tb_serial_word_packer.sv
// Bench for serial_word_packer: both bit orders side by side,
// queue-based reference model, directed cases then random traffic.
module tb_serial_word_packer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_;
  logic         bit_valid;
  logic         bit_in;
  logic         sof;
  logic         out_ready;
  logic         clear_flags;
  logic         vm, vl, om, ol, fm, fl;
  logic [W-1:0] dm, dl;

  always #5 clk = ~clk;

  serial_word_packer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset_(reset_), .bit_valid(bit_valid),
    .bit_in(bit_in), .sof(sof), .out_ready(out_ready),
    .clear_flags(clear_flags), .out_valid(vm), .out_data(dm),
    .overflow(om), .frame_err(fm)
  );

  serial_word_packer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset_(reset_), .bit_valid(bit_valid),
    .bit_in(bit_in), .sof(sof), .out_ready(out_ready),
    .clear_flags(clear_flags), .out_valid(vl), .out_data(dl),
    .overflow(ol), .frame_err(fl)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  logic         mq[$];
  bit           m_hunt = 1'b1;
  bit           m_vld  = 1'b0;
  logic [W-1:0] m_dm   = '0;
  logic [W-1:0] m_dl   = '0;
  bit           m_ovf  = 1'b0;
  bit           m_ferr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // advance the model by one clock using the current inputs
  task automatic model_step();
    bit           done = 1'b0;
    bit           oset = 1'b0;
    bit           fset = 1'b0;
    logic [W-1:0] wm = '0;
    logic [W-1:0] wl = '0;
    if (reset_) begin
      mq.delete();
      m_hunt = 1'b1; m_vld = 1'b0;
      m_dm = '0; m_dl = '0;
      m_ovf = 1'b0; m_ferr = 1'b0;
      return;
    end
    if (bit_valid) begin
      if (sof) begin
        if (!m_hunt && mq.size() != 0) fset = 1'b1;
        mq.delete();
        mq.push_back(bit_in);
        m_hunt = 1'b0;
      end else if (!m_hunt) begin
        mq.push_back(bit_in);
      end
      if (mq.size() == W) begin
        for (int k = 0; k < W; k++) begin
          wm[W-1-k] = mq[k];
          wl[k]     = mq[k];
        end
        mq.delete();
        done = 1'b1;
      end
    end
    if (done) begin
      if (!m_vld || out_ready) begin
        m_vld = 1'b1; m_dm = wm; m_dl = wl;
      end else begin
        oset = 1'b1;
      end
    end else if (m_vld && out_ready) begin
      m_vld = 1'b0;
    end
    m_ovf  = oset | (m_ovf & ~clear_flags);
    m_ferr = fset | (m_ferr & ~clear_flags);
  endtask

  task automatic cyc(input logic r, input logic bv, input logic b,
                     input logic s, input logic rdy, input logic clr);
    reset_ = r; bit_valid = bv; bit_in = b;
    sof = s; out_ready = rdy; clear_flags = clr;
    model_step();
    @(posedge clk);
    #1;
    check("vld_m", 32'(vm), 32'(m_vld));
    check("vld_l", 32'(vl), 32'(m_vld));
    check("dat_m", 32'(dm), 32'(m_dm));
    check("dat_l", 32'(dl), 32'(m_dl));
    check("ovf_m", 32'(om), 32'(m_ovf));
    check("ovf_l", 32'(ol), 32'(m_ovf));
    check("ferr_m", 32'(fm), 32'(m_ferr));
    check("ferr_l", 32'(fl), 32'(m_ferr));
  endtask

  // rdy_mode: 0 = never ready, 1 = always ready, 2 = ready on last bit
  task automatic send_byte(input logic [7:0] b, input bit s,
                           input bit gap, input int rdy_mode);
    logic rdy;
    for (int k = 0; k < 8; k++) begin
      rdy = (rdy_mode == 1) || (rdy_mode == 2 && k == 7);
      cyc(1'b0, 1'b1, b[7-k], s && k == 0, rdy, 1'b0);
      if (gap && k != 7) cyc(1'b0, 1'b0, 1'b0, 1'b0, rdy_mode == 1, 1'b0);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    reset_ = 1'b1; bit_valid = 1'b0; bit_in = 1'b0;
    sof = 1'b0; out_ready = 1'b0; clear_flags = 1'b0;

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("rst_vld", 32'(vm), 32'd0);
    check("rst_dat", 32'(dm), 32'd0);

    // basic word, both orders
    send_byte(8'hA5, 1'b1, 1'b0, 1);
    check("a5_m", 32'(dm), 32'hA5);
    check("a5_l", 32'(dl), 32'hA5);
    check("a5_v", 32'(vm), 32'd1);
    idle(1, 1'b1);
    check("a5_drop_v", 32'(vm), 32'd0);
    send_byte(8'hC0, 1'b0, 1'b0, 1);
    check("c0_m", 32'(dm), 32'hC0);
    check("c0_l", 32'(dl), 32'h03);
    idle(2, 1'b1);

    // three words with holes, no ready: first kept, overflow
    send_byte(8'h11, 1'b1, 1'b1, 0);
    idle(1, 1'b0);
    send_byte(8'h22, 1'b0, 1'b1, 0);
    idle(1, 1'b0);
    send_byte(8'h33, 1'b0, 1'b1, 0);
    check("ovr_dat", 32'(dm), 32'h11);
    check("ovr_flag", 32'(om), 32'd1);
    idle(1, 1'b1);
    check("ovr_xfer", 32'(vm), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_clr", 32'(om), 32'd0);

    // completion coincident with transfer
    send_byte(8'h11, 1'b0, 1'b0, 0);
    send_byte(8'h22, 1'b0, 1'b0, 2);
    check("same_dat", 32'(dm), 32'h22);
    check("same_vld", 32'(vm), 32'd1);
    check("same_ovf", 32'(om), 32'd0);
    idle(1, 1'b1);

    // hunt ignores bits; sof mid-word flags framing error
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("hunt_vld", 32'(vm), 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    send_byte(8'h5A, 1'b1, 1'b0, 0);
    check("ferr_set", 32'(fm), 32'd1);
    check("ferr_dat", 32'(dm), 32'h5A);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("ferr_clr", 32'(fm), 32'd0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("ferr_win", 32'(fm), 32'd1);

    // reset mid-word with a held word
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst2_vld", 32'(vm), 32'd0);
    check("rst2_dat", 32'(dm), 32'd0);
    send_byte(8'hFF, 1'b0, 1'b0, 1);
    check("rst2_hunt", 32'(vm), 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 200) == 0,
          ($urandom % 4) != 0,
          1'($urandom),
          ($urandom % 20) == 0,
          1'($urandom),
          ($urandom % 30) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
